// File: rtl/nanosoc_exp_region_mux.sv
// Expansion-region AHB interconnect: slot window decode, data-phase response mux,
// built-in ERROR default target and round-robin arbitration of slot DMA requests.
module nanosoc_exp_region_mux #(
    parameter int unsigned ADDRWIDTH      = 29,
    parameter int unsigned SLOT_ADDRWIDTH = 12,
    parameter int unsigned NUM_SLOTS      = 4,
    parameter int unsigned BASE_INDEX     = 'h10,
    parameter int unsigned SELW           = 3
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic                    HSELS,
    input  logic [ADDRWIDTH-1:0]    HADDRS,
    input  logic [1:0]              HTRANSS,
    input  logic                    HREADYS,
    output logic                    HREADYOUTS,
    output logic                    HRESPS,
    output logic [31:0]             HRDATAS,
    output logic [NUM_SLOTS-1:0]    HSEL_SLOT,
    input  logic [NUM_SLOTS-1:0]    HREADYOUT_SLOT,
    input  logic [NUM_SLOTS-1:0]    HRESP_SLOT,
    input  logic [32*NUM_SLOTS-1:0] HRDATA_SLOT,
    input  logic [NUM_SLOTS-1:0]    ip_req_slot,
    input  logic [NUM_SLOTS-1:0]    op_req_slot,
    output logic                    ip_data_req,
    output logic                    op_data_req,
    output logic [SELW-1:0]         dma_slot_sel
);

    localparam int unsigned IdxW = ADDRWIDTH - SLOT_ADDRWIDTH;
    localparam logic [IdxW-1:0] BaseIdx = IdxW'(BASE_INDEX);
    localparam logic [IdxW-1:0] NumSlotsIdx = IdxW'(NUM_SLOTS);
    // Pointer starts at the last slot so the first scan begins at slot 0.
    localparam logic [SELW-1:0] PtrRst = SELW'(NUM_SLOTS - 1);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [IdxW-1:0]      w_win;
    logic [IdxW-1:0]      w_idx;
    logic                 w_in_range;
    logic [NUM_SLOTS-1:0] w_hsel_slot;
    logic                 w_dflt_sel;
    logic                 w_unused_bits;

    assign w_win = HADDRS[ADDRWIDTH-1:SLOT_ADDRWIDTH];
    assign w_idx = w_win - BaseIdx;
    // Windows below the base would wrap the subtraction, so reject them explicitly.
    assign w_in_range = (w_win >= BaseIdx) && (w_idx < NumSlotsIdx);

    always_comb begin
        w_hsel_slot = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            w_hsel_slot[k] = HSELS & w_in_range & (w_idx == IdxW'(k));
        end
    end

    assign w_dflt_sel    = HSELS & ~(|w_hsel_slot);
    assign HSEL_SLOT     = w_hsel_slot;
    assign w_unused_bits = ^{HADDRS[SLOT_ADDRWIDTH-1:0], HTRANSS[0]};

    // ------------------------------------------------------------------
    // Data-phase select
    // ------------------------------------------------------------------
    logic [NUM_SLOTS:0] r_dsel;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_dsel <= '0;
        end else if (HREADYS) begin
            r_dsel <= {w_dflt_sel, w_hsel_slot};
        end
    end

    // ------------------------------------------------------------------
    // Default target: two-cycle ERROR for active transfers outside all windows
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {DfltIdle, DfltErr1, DfltErr2} dflt_state_e;

    dflt_state_e r_dflt_state;
    dflt_state_e w_dflt_state_nxt;
    logic        w_dflt_req;
    logic        w_dflt_ready;
    logic        w_dflt_resp;

    assign w_dflt_req = w_dflt_sel & HREADYS & HTRANSS[1];

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_dflt_state <= DfltIdle;
        end else begin
            r_dflt_state <= w_dflt_state_nxt;
        end
    end

    always_comb begin
        w_dflt_state_nxt = r_dflt_state;
        w_dflt_ready     = 1'b1;
        w_dflt_resp      = 1'b0;
        case (r_dflt_state)
            DfltIdle: begin
                if (w_dflt_req) begin
                    w_dflt_state_nxt = DfltErr1;
                end
            end
            DfltErr1: begin
                w_dflt_ready     = 1'b0;
                w_dflt_resp      = 1'b1;
                w_dflt_state_nxt = DfltErr2;
            end
            DfltErr2: begin
                w_dflt_resp      = 1'b1;
                w_dflt_state_nxt = w_dflt_req ? DfltErr1 : DfltIdle;
            end
            default: begin
                w_dflt_state_nxt = DfltIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Response mux
    // ------------------------------------------------------------------
    always_comb begin
        HREADYOUTS = 1'b1;
        HRESPS     = 1'b0;
        HRDATAS    = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (r_dsel[k]) begin
                HREADYOUTS = HREADYOUT_SLOT[k];
                HRESPS     = HRESP_SLOT[k];
                HRDATAS    = HRDATA_SLOT[32*k +: 32];
            end
        end
        if (r_dsel[NUM_SLOTS]) begin
            HREADYOUTS = w_dflt_ready;
            HRESPS     = w_dflt_resp;
            HRDATAS    = '0;
        end
    end

    // ------------------------------------------------------------------
    // DMA request arbiter
    // ------------------------------------------------------------------
    typedef enum logic {ArbIdle, ArbGrant} arb_state_e;

    arb_state_e           r_arb_state;
    arb_state_e           w_arb_state_nxt;
    logic [SELW-1:0]      r_grant;
    logic [SELW-1:0]      w_grant_nxt;
    logic [SELW-1:0]      r_ptr;
    logic [SELW-1:0]      w_ptr_nxt;
    logic [SELW-1:0]      w_pick;
    logic                 w_pick_vld;
    logic [NUM_SLOTS-1:0] w_req;
    logic                 w_g_ip;
    logic                 w_g_op;

    assign w_req = ip_req_slot | op_req_slot;

    // Lowest requester above the pointer wins; otherwise wrap to the lowest at or below it.
    always_comb begin
        w_pick     = '0;
        w_pick_vld = 1'b0;
        for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
            if (w_req[k] && (SELW'(k) <= r_ptr)) begin
                w_pick     = SELW'(k);
                w_pick_vld = 1'b1;
            end
        end
        for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
            if (w_req[k] && (SELW'(k) > r_ptr)) begin
                w_pick     = SELW'(k);
                w_pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        w_g_ip = 1'b0;
        w_g_op = 1'b0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (r_grant == SELW'(k)) begin
                w_g_ip = ip_req_slot[k];
                w_g_op = op_req_slot[k];
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_arb_state <= ArbIdle;
            r_grant     <= '0;
            r_ptr       <= PtrRst;
        end else begin
            r_arb_state <= w_arb_state_nxt;
            r_grant     <= w_grant_nxt;
            r_ptr       <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_arb_state_nxt = r_arb_state;
        w_grant_nxt     = r_grant;
        w_ptr_nxt       = r_ptr;
        case (r_arb_state)
            ArbIdle: begin
                if (w_pick_vld) begin
                    w_grant_nxt     = w_pick;
                    w_arb_state_nxt = ArbGrant;
                end
            end
            ArbGrant: begin
                if (!(w_g_ip || w_g_op)) begin
                    w_ptr_nxt       = r_grant;
                    w_arb_state_nxt = ArbIdle;
                end
            end
            default: begin
                w_arb_state_nxt = ArbIdle;
            end
        endcase
    end

    assign ip_data_req  = (r_arb_state == ArbGrant) & w_g_ip;
    assign op_data_req  = (r_arb_state == ArbGrant) & w_g_op;
    assign dma_slot_sel = r_grant;

endmodule

// File: doc/nanosoc_exp_region_mux.md
Name: nanosoc_exp_region_mux

Overview:
- Parametrised AHB interconnect for the nanosoc expansion region.
- Decodes the region address space into NUM_SLOTS equal accelerator windows. Any address outside those windows goes to a built-in default target that returns a two-cycle ERROR response.
- Registers the data-phase select and multiplexes slot responses back to the initiator.
- Arbitrates the per-slot DMA data-request pairs onto the region's single ip/op DMA request pair using a round-robin arbiter.
- Sits between the expansion-region AHB port and the accelerator wrappers. Slot wrappers take HADDRS/HTRANSS/HWDATAS etc. directly from the region bus.

Parameters:
- ADDRWIDTH, 29: region address width.
- SLOT_ADDRWIDTH, 12: per-slot window width. Each window is 2^SLOT_ADDRWIDTH bytes.
- NUM_SLOTS, 4: number of accelerator slots, range 1..8.
- BASE_INDEX, 'h10: window index of slot 0, i.e. HADDRS[ADDRWIDTH-1:SLOT_ADDRWIDTH] value.
- SELW, 3: width of dma_slot_sel. Must satisfy 2^SELW >= NUM_SLOTS.

Ports:
- HCLK  in  1  clock
- HRESET  in  1  reset
- HSELS  in  1  region select
- HADDRS  in  ADDRWIDTH  address
- HTRANSS  in  2  transfer type
- HREADYS  in  1  bus ready
- HREADYOUTS  out  1  ready to initiator
- HRESPS  out  1  response to initiator
- HRDATAS  out  32  read data to initiator
- HSEL_SLOT  out  NUM_SLOTS  one-hot address-phase slot select
- HREADYOUT_SLOT  in  NUM_SLOTS  slot ready
- HRESP_SLOT  in  NUM_SLOTS  slot response
- HRDATA_SLOT  in  32*NUM_SLOTS  slot read data; slot k occupies [32k+31:32k]
- ip_req_slot  in  NUM_SLOTS  per-slot input-data DMA request
- op_req_slot  in  NUM_SLOTS  per-slot output-data DMA request
- ip_data_req  out  1  arbitrated input-data request
- op_data_req  out  1  arbitrated output-data request
- dma_slot_sel  out  SELW  slot currently owning the DMA requests

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high. HRESET is sampled on the HCLK rising edge.
- Reset values:
  - HREADYOUTS=1, HRESPS=0, HRDATAS=0.
  - ip_data_req=0, op_data_req=0, dma_slot_sel=0.
  - Data-phase select = none; default FSM = IDLE; arbiter = IDLE.
  - Round-robin pointer set so slot 0 has highest priority first.
- Address decode (combinational):
  - idx = HADDRS[ADDRWIDTH-1:SLOT_ADDRWIDTH] - BASE_INDEX.
  - HSEL_SLOT[k] = HSELS & (idx==k), for k < NUM_SLOTS.
  - dflt_sel = HSELS & no slot hit.
  - Underflow (idx negative) or idx >= NUM_SLOTS → default target.
- Data-phase select:
  - Register of NUM_SLOTS+1 one-hot bits. Loads {dflt_sel, HSEL_SLOT} when HREADYS=1; holds otherwise.
  - When no bit is set: HREADYOUTS=1, HRESPS=0, HRDATAS=0.
- Output mux: HREADYOUTS/HRESPS/HRDATAS come from the data-phase-selected slot or the default target. Purely combinational from the register plus slot inputs; no added latency.
- Default target FSM, states IDLE → ERR1 → ERR2:
  - IDLE: if dflt_sel & HREADYS & HTRANSS[1], go to ERR1. Otherwise output HREADYOUT=1, HRESP=0 (IDLE/BUSY transfers get a zero-wait OKAY).
  - ERR1: HREADYOUT=0, HRESP=1. Always go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. If a new qualifying transfer is sampled, go to ERR1; else go to IDLE.
  - Default read data is always 0.
- DMA arbiter, states IDLE / GRANT:
  - r_k = ip_req_slot[k] | op_req_slot[k].
  - IDLE: if any r_k, grant the first requester at or after pointer+1 (wrapping modulo NUM_SLOTS). Register the grant into dma_slot_sel and go to GRANT.
  - GRANT:
    - ip_data_req = ip_req_slot[g]; op_data_req = op_req_slot[g] (combinational from the granted slot).
    - Hold the grant while r_g=1.
    - When r_g=0: pointer<=g and return to IDLE. This gives a mandatory one-cycle gap with both outputs 0.
  - IDLE outputs: ip_data_req=op_data_req=0. dma_slot_sel keeps its last value.
  - Latency: request to output is 1 cycle from IDLE.
  - Requests from non-granted slots are ignored and never dropped; they are served on later arbitration.
- Reset mid-transfer: reset aborts any ERROR sequence and DMA grant. Outputs reach their reset values in the cycle after HRESET is sampled high.

Test Plan:
Configuration for all scenarios: defaults, slots at 0x10000/0x11000/0x12000/0x13000.
1. NONSEQ read of 0x11004 with slot 1 returning HRDATA=0xCAFE0001, OKAY, zero wait → HSEL_SLOT=4'b0010 in the address phase; HRDATAS=0xCAFE0001 and HREADYOUTS=1 in the next cycle.
2. Slot 2 holds HREADYOUT_SLOT[2]=0 for 3 cycles on a write to 0x12000 → HREADYOUTS=0 for exactly 3 cycles; the data-phase select does not change while HREADYS=0.
3. NONSEQ to 0x14000, then to 0x0F000 → each gives {HREADYOUTS,HRESPS} = {0,1} then {1,1}. An IDLE transfer to 0x14000 gives {1,0} immediately.
4. ip_req_slot=4'b0110 asserted together from reset → dma_slot_sel=1 one cycle later and ip_data_req=1. Deassert slot 1 → one gap cycle with outputs 0, then dma_slot_sel=2.
5. All four slots request continuously, each dropping its request for 1 cycle after 5 cycles of grant → grant order 0,1,2,3,0 with no starvation.
6. Assert HRESET during ERR1 and during GRANT → next cycle HREADYOUTS=1, HRESPS=0, ip_data_req=op_data_req=0, dma_slot_sel=0.
